// File: rtl/decode_issue_stage.sv
// RV32 decode/issue stage: register file, per-register scoreboard and a registered
// execute bundle with valid/ready handshakes. Define DECODE_WB_BYPASS_EN to forward same-cycle writebacks.
module decode_issue_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid_ip,
    output logic                  instr_ready_op,
    input  logic [31:0]           instr_data_ip,
    input  logic [XLEN-1:0]       pc_ip,
    input  logic                  flush_ip,
    output logic                  ex_valid_op,
    input  logic                  ex_ready_ip,
    output logic [ALU_OP_W-1:0]   ex_alu_operator_op,
    output logic [XLEN-1:0]       ex_operand_a_op,
    output logic [XLEN-1:0]       ex_operand_b_op,
    output logic [XLEN-1:0]       ex_store_data_op,
    output logic                  ex_lsu_en_op,
    output logic                  ex_lsu_we_op,
    output logic [REG_ADDR_W-1:0] ex_rd_op,
    output logic                  ex_rd_we_op,
    input  logic                  wb_valid_ip,
    input  logic [REG_ADDR_W-1:0] wb_rd_ip,
    input  logic [XLEN-1:0]       wb_data_ip,
    output logic                  redirect_valid_op,
    output logic [XLEN-1:0]       redirect_target_op,
    output logic                  illegal_instr_op
);

    localparam int NREG = 2 ** REG_ADDR_W;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    localparam logic [ALU_OP_W-1:0] ALU_NOP  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLTS = ALU_OP_W'(3);

    logic [XLEN-1:0] regs_reg [NREG];
    logic [NREG-1:0] pending_reg;

    // Instruction fields
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rd_idx, rs1_idx, rs2_idx;
    logic [XLEN-1:0]       imm_i, imm_s, imm_j;

    assign opcode  = instr_data_ip[6:0];
    assign funct3  = instr_data_ip[14:12];
    assign funct7  = instr_data_ip[31:25];
    assign rd_idx  = instr_data_ip[7 +: REG_ADDR_W];
    assign rs1_idx = instr_data_ip[15 +: REG_ADDR_W];
    assign rs2_idx = instr_data_ip[20 +: REG_ADDR_W];
    assign imm_i   = {{(XLEN-12){instr_data_ip[31]}}, instr_data_ip[31:20]};
    assign imm_s   = {{(XLEN-12){instr_data_ip[31]}}, instr_data_ip[31:25], instr_data_ip[11:7]};
    assign imm_j   = {{(XLEN-21){instr_data_ip[31]}}, instr_data_ip[31], instr_data_ip[19:12],
                      instr_data_ip[20], instr_data_ip[30:21], 1'b0};

    logic                dec_legal, dec_use_rs1, dec_use_rs2, dec_writes_rd;
    logic                dec_is_op, dec_is_i, dec_is_store, dec_is_jal;
    logic [ALU_OP_W-1:0] dec_alu;

    always_comb begin
        dec_legal     = 1'b0;
        dec_use_rs1   = 1'b0;
        dec_use_rs2   = 1'b0;
        dec_writes_rd = 1'b0;
        dec_is_op     = 1'b0;
        dec_is_i      = 1'b0;
        dec_is_store  = 1'b0;
        dec_is_jal    = 1'b0;
        dec_alu       = ALU_NOP;
        case (opcode)
            OPC_OP: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_alu   = ALU_ADD;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_legal = 1'b1;
                    dec_alu   = ALU_SUB;
                end else if (funct3 == 3'b010 && funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_alu   = ALU_SLTS;
                end
                dec_is_op     = dec_legal;
                dec_use_rs1   = dec_legal;
                dec_use_rs2   = dec_legal;
                dec_writes_rd = dec_legal;
            end
            OPC_OPIMM, OPC_LOAD: begin
                if (funct3 == ((opcode == OPC_LOAD) ? 3'b010 : 3'b000)) begin
                    dec_legal     = 1'b1;
                    dec_alu       = ALU_ADD;
                    dec_is_i      = 1'b1;
                    dec_use_rs1   = 1'b1;
                    dec_writes_rd = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    dec_legal    = 1'b1;
                    dec_alu      = ALU_ADD;
                    dec_is_store = 1'b1;
                    dec_use_rs1  = 1'b1;
                    dec_use_rs2  = 1'b1;
                end
            end
            OPC_JAL: begin
                dec_legal     = 1'b1;
                dec_alu       = ALU_ADD;
                dec_is_jal    = 1'b1;
                dec_writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Hazard detection: a register is busy if the scoreboard or the bundle in flight will write it
    logic            ex_hit_rs1, ex_hit_rs2, ex_hit_rd;
    logic            rs1_busy, rs2_busy, rd_busy, hazard;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign ex_hit_rs1 = ex_valid_op && ex_rd_we_op && (ex_rd_op == rs1_idx);
    assign ex_hit_rs2 = ex_valid_op && ex_rd_we_op && (ex_rd_op == rs2_idx);
    assign ex_hit_rd  = ex_valid_op && ex_rd_we_op && (ex_rd_op == rd_idx);

    always_comb begin
        rs1_val  = regs_reg[rs1_idx];
        rs2_val  = regs_reg[rs2_idx];
        rs1_busy = dec_use_rs1 && (rs1_idx != '0) && (pending_reg[rs1_idx] || ex_hit_rs1);
        rs2_busy = dec_use_rs2 && (rs2_idx != '0) && (pending_reg[rs2_idx] || ex_hit_rs2);
`ifdef DECODE_WB_BYPASS_EN
        // A source waiting only on the scoreboard can take the writeback arriving this cycle
        if (rs1_busy && !ex_hit_rs1 && wb_valid_ip && wb_rd_ip == rs1_idx) begin
            rs1_busy = 1'b0;
            rs1_val  = wb_data_ip;
        end
        if (rs2_busy && !ex_hit_rs2 && wb_valid_ip && wb_rd_ip == rs2_idx) begin
            rs2_busy = 1'b0;
            rs2_val  = wb_data_ip;
        end
`endif
        rd_busy = dec_writes_rd && (rd_idx != '0) && (pending_reg[rd_idx] || ex_hit_rd);
        hazard  = rs1_busy || rs2_busy || rd_busy;
    end

    logic accept, complete;
    assign instr_ready_op = !reset && (!ex_valid_op || ex_ready_ip) && !hazard && !flush_ip;
    assign accept         = instr_valid_ip && instr_ready_op;
    assign complete       = ex_valid_op && ex_ready_ip;

    // Register file and scoreboard, one slice per architectural register; slice 0 never changes
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    regs_reg[gi]    <= '0;
                    pending_reg[gi] <= 1'b0;
                end else if (gi != 0) begin
                    if (wb_valid_ip && wb_rd_ip == REG_ADDR_W'(gi))
                        regs_reg[gi] <= wb_data_ip;
                    if (complete && ex_rd_we_op && ex_rd_op == REG_ADDR_W'(gi))
                        pending_reg[gi] <= 1'b1;
                    else if (wb_valid_ip && wb_rd_ip == REG_ADDR_W'(gi))
                        pending_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    logic [XLEN-1:0] op_a_next, op_b_next;
    always_comb begin
        op_a_next = '0;
        op_b_next = '0;
        if (dec_is_jal) begin
            op_a_next = pc_ip;
            op_b_next = XLEN'(4);
        end else if (dec_legal) begin
            op_a_next = rs1_val;
            if (dec_is_op)
                op_b_next = rs2_val;
            else if (dec_is_store)
                op_b_next = imm_s;
            else
                op_b_next = imm_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid_op        <= 1'b0;
            ex_alu_operator_op <= ALU_NOP;
            ex_operand_a_op    <= '0;
            ex_operand_b_op    <= '0;
            ex_store_data_op   <= '0;
            ex_lsu_en_op       <= 1'b0;
            ex_lsu_we_op       <= 1'b0;
            ex_rd_op           <= '0;
            ex_rd_we_op        <= 1'b0;
            redirect_valid_op  <= 1'b0;
            redirect_target_op <= '0;
            illegal_instr_op   <= 1'b0;
        end else begin
            redirect_valid_op <= accept && dec_is_jal;
            illegal_instr_op  <= accept && !dec_legal;
            if (accept && dec_is_jal)
                redirect_target_op <= pc_ip + imm_j;
            if (accept) begin
                ex_valid_op        <= dec_legal;
                ex_alu_operator_op <= dec_alu;
                ex_operand_a_op    <= op_a_next;
                ex_operand_b_op    <= op_b_next;
                ex_store_data_op   <= dec_is_store ? rs2_val : '0;
                ex_lsu_en_op       <= dec_legal && (opcode == OPC_LOAD || dec_is_store);
                ex_lsu_we_op       <= dec_is_store;
                ex_rd_op           <= (dec_writes_rd) ? rd_idx : '0;
                ex_rd_we_op        <= dec_writes_rd && (rd_idx != '0);
            end else if (complete || flush_ip) begin
                // A flush only drops a stalled bundle; a completing one has already been taken
                ex_valid_op <= 1'b0;
            end
        end
    end

endmodule
